// File: rtl/schem_sweep_seq.sv
// Stimulus sequencer for the Schem stage: walks x3..x0 through codes 0..15, holding each for DWELL cycles.
// Define SCHEM_SWEEP_SIG_EN to fold y3..y0 into a rotate/XOR signature; otherwise sig is constant zero.
module schem_sweep_seq #(
  parameter int DWELL = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  output logic        x3,
  output logic        x2,
  output logic        x1,
  output logic        x0,
  input  logic        y3,
  input  logic        y2,
  input  logic        y1,
  input  logic        y0,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig
);

  if (DWELL < 1 || DWELL > 1024) begin : g_bad_dwell
    $error("schem_sweep_seq: DWELL must be in 1..1024");
  end

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic accept;
  logic sample_pt;

  // Any non-RUN state (including the unused encoding) accepts start.
  assign accept    = (state_q != ST_RUN) && start;
  assign sample_pt = (state_q == ST_RUN) && !hold && (dwell_q == DWELL_LAST);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dwell_d = dwell_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (state_q == ST_RUN) begin
      if (!hold) begin
        if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 1'b1;
        end else begin
          dwell_d = '0;
          if (code_q != 4'hF) begin
            code_d = code_q + 4'd1;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    end else if (accept) begin
      state_d = ST_RUN;
      code_d  = '0;
      dwell_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SCHEM_SWEEP_SIG_EN
  logic [15:0] sig_q, sig_d;

  // y is combinational from x, so the current y belongs to the current code.
  always_comb begin
    sig_d = sig_q;
    if (accept) begin
      sig_d = '0;
    end else if (sample_pt) begin
      sig_d = {sig_q[14:0], sig_q[15]} ^ {12'b0, y3, y2, y1, y0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`else
  logic unused_sig_inputs;
  assign unused_sig_inputs = ^{y3, y2, y1, y0, sample_pt};
  assign sig = '0;
`endif

  assign {x3, x2, x1, x0} = code_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_schem_sweep_seq.sv
// Directed bench for schem_sweep_seq: three instances (DWELL=10, 2, 1) sharing rst, hold and y.
module tb_schem_sweep_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       hold;
  logic [2:0] start_v;
  logic [3:0] y;

  wire [3:0]  x_a, x_b, x_c;
  wire        busy_a, busy_b, busy_c;
  wire        done_a, done_b, done_c;
  wire [15:0] sig_a, sig_b, sig_c;

  int tests;
  int fails;

`ifdef SCHEM_SWEEP_SIG_EN
  localparam logic [15:0] SIG_ONE = 16'hFFFF;
`else
  localparam logic [15:0] SIG_ONE = 16'h0000;
`endif

  schem_sweep_seq #(.DWELL(10)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .hold(hold),
    .x3(x_a[3]), .x2(x_a[2]), .x1(x_a[1]), .x0(x_a[0]),
    .y3(y[3]), .y2(y[2]), .y1(y[1]), .y0(y[0]),
    .busy(busy_a), .done(done_a), .sig(sig_a)
  );

  schem_sweep_seq #(.DWELL(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .hold(hold),
    .x3(x_b[3]), .x2(x_b[2]), .x1(x_b[1]), .x0(x_b[0]),
    .y3(y[3]), .y2(y[2]), .y1(y[1]), .y0(y[0]),
    .busy(busy_b), .done(done_b), .sig(sig_b)
  );

  schem_sweep_seq #(.DWELL(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .hold(hold),
    .x3(x_c[3]), .x2(x_c[2]), .x1(x_c[1]), .x0(x_c[0]),
    .y3(y[3]), .y2(y[2]), .y1(y[1]), .y0(y[0]),
    .busy(busy_c), .done(done_c), .sig(sig_c)
  );

  int         sel;
  logic [3:0] x_mon;
  logic       busy_mon;
  logic       done_mon;
  logic [15:0] sig_mon;

  always_comb begin
    case (sel)
      1:       begin x_mon = x_b; busy_mon = busy_b; done_mon = done_b; sig_mon = sig_b; end
      2:       begin x_mon = x_c; busy_mon = busy_c; done_mon = done_c; sig_mon = sig_c; end
      default: begin x_mon = x_a; busy_mon = busy_a; done_mon = done_a; sig_mon = sig_a; end
    endcase
  end

  function automatic int dwell_of(input int s);
    case (s)
      1:       return 2;
      2:       return 1;
      default: return 10;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep on instance s; hold is high for hl edges beginning at busy cycle hs;
  // start is re-pulsed at busy cycle st_n (negative = never).
  task automatic run_sweep(input int s, input int hs, input int hl, input int st_n,
                           input logic [15:0] exp_sig, input string tag);
    int d;
    int n;
    int m;
    logic held;
    d   = dwell_of(s);
    sel = s;
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    tests++;
    if ({x_mon, busy_mon, done_mon, sig_mon} !== {4'h0, 1'b1, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL %s_accept: x/busy/done/sig = %h/%b/%b/%h, expected 0/1/0/0000",
               tag, x_mon, busy_mon, done_mon, sig_mon);
    end
    n = 0;
    m = 0;
    while (busy_mon === 1'b1 && n < 20 * d + 100) begin
      tests++;
      if (x_mon !== 4'(m / d)) begin
        fails++;
        $display("FAIL %s_x: busy cycle %0d x=%h, expected %h", tag, n, x_mon, 4'(m / d));
      end
      held = (n >= hs) && (n < hs + hl);
      hold = held;
      if (n == st_n) start_v[s] = 1'b1;
      tick();
      hold = 1'b0;
      start_v[s] = 1'b0;
      n++;
      if (!held) m++;
    end
    tests++;
    if (n != 16 * d + hl) begin
      fails++;
      $display("FAIL %s_busy_len: busy cycles=%0d, expected %0d", tag, n, 16 * d + hl);
    end
    tests++;
    if ({x_mon, busy_mon, done_mon} !== {4'hF, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL %s_done: x/busy/done = %h/%b/%b, expected F/0/1", tag, x_mon, busy_mon, done_mon);
    end
    tests++;
    if (sig_mon !== exp_sig) begin
      fails++;
      $display("FAIL %s_sig: sig=%h, expected %h", tag, sig_mon, exp_sig);
    end
    tick();
    tick();
    tick();
    tests++;
    if ({x_mon, busy_mon, done_mon, sig_mon} !== {4'hF, 1'b0, 1'b1, exp_sig}) begin
      fails++;
      $display("FAIL %s_done_sticky: x/busy/done/sig = %h/%b/%b/%h, expected F/0/1/%h",
               tag, x_mon, busy_mon, done_mon, sig_mon, exp_sig);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      tests++;
      if ({x_mon, busy_mon, done_mon, sig_mon} !== 23'h0) begin
        fails++;
        $display("FAIL reset_state[%0d]: x/busy/done/sig = %h/%b/%b/%h, expected 0/0/0/0000",
                 s, x_mon, busy_mon, done_mon, sig_mon);
      end
    end
    sel = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if ({x_mon, busy_mon, done_mon, sig_mon} !== 23'h0) begin
        fails++;
        $display("FAIL reset_idle: cycle %0d x/busy/done/sig = %h/%b/%b/%h, expected 0/0/0/0000",
                 i, x_mon, busy_mon, done_mon, sig_mon);
      end
    end
  endtask

  task automatic test_full_sweep();
    y = 4'h0;
    run_sweep(0, 0, 0, -1, 16'h0000, "sweep_d10");
  endtask

  task automatic test_hold();
    y = 4'h0;
    run_sweep(1, 12, 5, -1, 16'h0000, "hold_d2");
  endtask

  task automatic test_signature();
    y = 4'h1;
    run_sweep(2, 0, 0, -1, SIG_ONE, "sig_d1_y1");
    y = 4'h0;
    run_sweep(2, 0, 0, -1, 16'h0000, "sig_d1_y0");
    y = 4'h1;
    run_sweep(0, 0, 0, -1, SIG_ONE, "sig_d10_y1");
    y = 4'h0;
  endtask

  task automatic test_mid_reset();
    int n;
    y   = 4'h1;
    sel = 0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    n = 0;
    while (x_mon !== 4'h9 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (x_mon !== 4'h9) begin
      fails++;
      $display("FAIL mid_reset_reach: x=%h after %0d cycles, expected 9", x_mon, n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({x_mon, busy_mon, done_mon, sig_mon} !== 23'h0) begin
      fails++;
      $display("FAIL mid_reset_clear: x/busy/done/sig = %h/%b/%b/%h, expected 0/0/0/0000",
               x_mon, busy_mon, done_mon, sig_mon);
    end
    y = 4'h0;
    run_sweep(0, 0, 0, -1, 16'h0000, "after_reset");
  endtask

  task automatic test_back_to_back();
    y = 4'h1;
    run_sweep(0, 0, 0, 30, SIG_ONE, "start_busy");
    y = 4'h0;
    run_sweep(0, 0, 0, -1, 16'h0000, "start_done");
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    sel     = 0;
    rst     = 1'b1;
    hold    = 1'b0;
    start_v = '0;
    y       = 4'h0;
    test_reset();
    test_full_sweep();
    test_hold();
    test_signature();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/schem_sweep_seq.md
Name: schem_sweep_seq

Overview:
- Upstream stimulus sequencer for the 4-input/4-output combinational Schem stage.
- Drives x3..x0 through all 16 codes (0000 to 1111, x3 = MSB) in ascending order, holding each code for DWELL clock cycles.
- Reports busy and done status.
- Optionally folds the Schem outputs y3..y0 into a 16-bit signature, so the whole truth table can be checked with one compare.

Parameters:
- DWELL, default 10: cycles each code is held. Legal range 1..1024. The elaboration fails if DWELL < 1.

Ports:
- clk  input  1  single system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- hold  input  1  while high, freezes the sweep on the current code.
- x3  output  1  stimulus bit 3 (MSB) to Schem.
- x2  output  1  stimulus bit 2 to Schem.
- x1  output  1  stimulus bit 1 to Schem.
- x0  output  1  stimulus bit 0 (LSB) to Schem.
- y3  input  1  Schem output bit 3 (MSB).
- y2  input  1  Schem output bit 2.
- y1  input  1  Schem output bit 1.
- y0  input  1  Schem output bit 0 (LSB).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high once a sweep has completed; stays high until the next start or rst.
- sig  output  16  signature of sampled y values.

Interface:
- One clock, clk. Reset is rst: synchronous, active-high.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (rst=1 at a clk edge): state=IDLE, code=0, dwell=0, x3..x0=0000, busy=0, done=0, sig=0. rst has priority over every other input, including in the middle of a sweep.
- State IDLE or DONE:
  - start=1 at edge k → state=RUN, code=0, dwell=0, done=0, sig=0.
  - busy=1 and x=0000 are visible from cycle k+1.
- State RUN, per edge:
  - hold=1: no change to code, dwell or sig; x stays stable.
  - hold=0, dwell < DWELL-1: dwell increments.
  - hold=0, dwell = DWELL-1: this is the sample point.
    - sig updates (see Optional Feature).
    - If code < 15: code increments, dwell=0.
    - If code = 15: state=DONE, busy=0, done=1. x stays at 1111.
- x3..x0 always equal the current code.
- start while in RUN is ignored. start and hold together in IDLE: start is accepted, and hold is applied from the next cycle.
- Sweep length with hold=0 throughout: exactly 16*DWELL cycles of busy=1. done rises on the cycle after the last busy cycle.
- dwell counter width: clog2(DWELL), minimum 1 bit. For DWELL=1 the dwell counter is always 0, so every RUN cycle is a sample point.
- The Schem stage is combinational, so y is sampled in the same cycle as the x it corresponds to. With DWELL=1 the sample is still valid.
- A new start in DONE clears sig and done and reruns the sweep.

Optional Feature:
- Macro: SCHEM_SWEEP_SIG_EN.
- Defined: at each sample point, sig <= {sig[14:0], sig[15]} XOR {12'b0, y3, y2, y1, y0}. That is a 1-bit left rotate followed by XOR of y into bits 3..0. sig is cleared on start acceptance and on rst. Its final value is valid while done=1.
- Not defined: sig is tied to 16'h0000. y3..y0 remain as ports but are ignored. No signature logic is synthesised.

Test Plan:
- Reset: rst=1 for 2 cycles, then idle → x=0000, busy=0, done=0, sig=0000. Outputs stay unchanged for 20 cycles with start=0.
- Full sweep, DWELL=10, hold=0, start pulsed once → x steps 0000,0001,…,1111, each code exactly 10 cycles. busy is high for 160 cycles; done rises on cycle 161 and stays high.
- Hold, DWELL=2: assert hold for 5 cycles while code=0110 → x stays 0110 for 7 cycles total. Total busy = 37 cycles.
- Signature (SCHEM_SWEEP_SIG_EN defined), DWELL=1: y tied to 0001 → sig=FFFF at done. y tied to 0000 → sig=0000. Without the macro → sig=0000 in both cases.
- rst=1 at code=1001 mid-sweep → next cycle x=0000, busy=0, done=0, sig=0. A subsequent start runs a full 16-code sweep.
- start pulsed while busy (code=0011) → ignored; the sweep completes normally. start in DONE → done=0, sig=0, and the sweep restarts at 0000.
